// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch unit, the LSU, the arbiter and memory.
// The arbiter takes the master view; requesters and memory share the slave view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_mask;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_mask,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_mask,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / LSU) single-port memory arbiter with LSU priority,
// bounded fetch starvation and a per-transaction acknowledge timeout.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

    state_t      state, state_nxt;
    logic        gnt_if, gnt_ls;
    logic        done_ack, done_to;
    logic [3:0]  starve_cnt;
    logic [7:0]  wait_cnt;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Timeout fires in the last allowed BUSY cycle so mem_req stays up exactly TIMEOUT cycles;
    // an ack in that same cycle wins.
    always_comb begin
        state_nxt = state;
        gnt_if    = 1'b0;
        gnt_ls    = 1'b0;
        done_ack  = 1'b0;
        done_to   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ls_req && (!bus.if_req || starve_cnt < STARVE_LIM)) begin
                    gnt_ls    = 1'b1;
                    state_nxt = BUSY_LS;
                end else if (bus.if_req) begin
                    gnt_if    = 1'b1;
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (bus.mem_ack) begin
                    done_ack  = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    done_to   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            wait_cnt   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
        end else begin
            if (gnt_ls && bus.if_req && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
            else if (gnt_if)                                 starve_cnt <= '0;

            if (gnt_if || gnt_ls)                            wait_cnt <= '0;
            else if (state != IDLE && !bus.mem_ack)          wait_cnt <= wait_cnt + 8'd1;

            if (gnt_ls) begin
                we_q    <= bus.ls_we;
                addr_q  <= bus.ls_addr;
                wdata_q <= bus.ls_wdata;
                mask_q  <= bus.ls_mask;
            end else if (gnt_if) begin
                we_q    <= 1'b0;
                addr_q  <= bus.if_addr;
                wdata_q <= '0;
                mask_q  <= 4'hF;
            end
        end
    end

    // Responses: rvalid/err pulse for one cycle; rdata only moves on a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.if_rvalid <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.ls_rvalid <= 1'b0;
            bus.ls_err    <= 1'b0;
            bus.ls_rdata  <= '0;
        end else begin
            bus.if_rvalid <= (state == BUSY_IF) && (done_ack || done_to);
            bus.if_err    <= (state == BUSY_IF) && done_to;
            bus.ls_rvalid <= (state == BUSY_LS) && (done_ack || done_to);
            bus.ls_err    <= (state == BUSY_LS) && done_to;
            if (state == BUSY_IF && (done_ack || done_to))
                bus.if_rdata <= done_ack ? bus.mem_rdata : 32'h0;
            if (state == BUSY_LS && (done_ack || done_to))
                bus.ls_rdata <= (done_ack && !we_q) ? bus.mem_rdata : 32'h0;
        end
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.ls_gnt    = gnt_ls;
    assign bus.mem_req   = (state != IDLE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_mask  = mask_q;
endmodule
